input_debouncer: RTL and testbench

// - Sits directly downstream of the single-bit D flip-flop stage. Takes a raw, possibly

---
 rtl/debounce_pkg.sv | 18 +
 rtl/sync_chain.sv | 35 +++
 rtl/input_debouncer.sv | 121 ++++++++++++
 tb/tb_input_debouncer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer.
//   db_state_t        : stability FSM states (STABLE = q settled, CHK = qualifying a new level)
//   MIN_SYNC_STAGES   : fewest synchronizer flops that still give metastability protection
//   MIN_STABLE_CYCLES : fewest consecutive equal samples accepted as a new level
//   cnt_width()       : width of the qualification counter for a given STABLE_CYCLES
package debounce_pkg;

   typedef enum logic {STABLE, CHK} db_state_t;

   localparam int MIN_SYNC_STAGES   = 2;
   localparam int MIN_STABLE_CYCLES = 2;

   // The counter must be able to represent STABLE_CYCLES.
   function automatic int cnt_width(input int stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Parameterised flop chain that brings an asynchronous level into the clk domain.
//   clk : clock, all flops update on the rising edge
//   rst : synchronous active-high reset, clears every stage to 0
//   d   : raw asynchronous input
//   q   : output of the last stage (STAGES edges of delay, no combinational path from d)
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stage_reg;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (rst) stage_reg[gi] <= 1'b0;
               else     stage_reg[gi] <= d;
            end
         end else begin : g_rest
            always_ff @(posedge clk) begin
               if (rst) stage_reg[gi] <= 1'b0;
               else     stage_reg[gi] <= stage_reg[gi-1];
            end
         end
      end
   endgenerate

   assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw level: synchronizes it, then only accepts a new level once the
// synchronized value has differed from q for STABLE_CYCLES consecutive edges.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (wins over everything in the same edge)
//   d    : raw, possibly asynchronous and bouncy input level
//   q    : debounced level (registered)
//   rise : one-cycle pulse in the cycle q goes 0->1 (registered)
//   fall : one-cycle pulse in the cycle q goes 1->0 (registered)
//   busy : high while a candidate level is being qualified (registered, state == CHK)
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int CNT_W = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   generate
      if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
         $error("input_debouncer: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
      end
      if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_bad_stable
         $error("input_debouncer: STABLE_CYCLES must be >= %0d", MIN_STABLE_CYCLES);
      end
   endgenerate

   logic d_sync;

   sync_chain #(
      .STAGES(SYNC_STAGES)
   ) u_sync_chain (
      .clk(clk),
      .rst(rst),
      .d  (d),
      .q  (d_sync)
   );

   db_state_t        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg,   cnt_next;
   logic             q_reg,     q_next;
   logic             rise_reg,  rise_next;
   logic             fall_reg,  fall_next;
   logic             busy_reg,  busy_next;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      q_next     = q_reg;
      // Strobes last a single cycle: cleared on every edge unless re-armed below.
      rise_next  = 1'b0;
      fall_next  = 1'b0;

      case (state_reg)
         STABLE: begin
            if (d_sync != q_reg) begin
               // The first differing sample already counts as one.
               state_next = CHK;
               cnt_next   = CNT_ONE;
            end else begin
               cnt_next   = '0;
            end
         end
         CHK: begin
            if (d_sync == q_reg) begin
               // Bounce back to the current level: abandon the candidate silently.
               state_next = STABLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               q_next     = d_sync;
               rise_next  = d_sync;
               fall_next  = ~d_sync;
               state_next = STABLE;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt_reg + CNT_ONE;
            end
         end
         default: begin
            state_next = STABLE;
            cnt_next   = '0;
         end
      endcase

      busy_next = (state_next == CHK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= STABLE;
         cnt_reg   <= '0;
         q_reg     <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         q_reg     <= q_next;
         rise_reg  <= rise_next;
         fall_reg  <= fall_next;
         busy_reg  <= busy_next;
      end
   end

   assign q    = q_reg;
   assign rise = rise_reg;
   assign fall = fall_reg;
   assign busy = busy_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer (SYNC_STAGES=2, STABLE_CYCLES=4).
// Each scenario pushes its per-edge expected {q, rise, fall, busy} vectors,
// then drives d/rst edge by edge and pops one expectation per edge.
module tb_input_debouncer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic d   = 1'b0;
   logic q, rise, fall, busy;

   int n_checks = 0;
   int n_fails  = 0;

   logic [3:0] sb[$];   // {q, rise, fall, busy}

   input_debouncer #(
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .q   (q),
      .rise(rise),
      .fall(fall),
      .busy(busy)
   );

   always #10 clk = ~clk;

   // Apply inputs for the next edge, wait for it, then settle away from the edge.
   task automatic drive_edge(input logic d_val, input logic rst_val);
      d   = d_val;
      rst = rst_val;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] exp_v;
      logic [3:0] obs;
      for (int k = 1; k <= 7; k++) sb.push_back(4'b0000);
      for (int k = 1; k <= 7; k++) begin
         // Reset held for 3 edges with d=1, then idle with d=0.
         if (k <= 3) drive_edge(1'b1, 1'b1);
         else        drive_edge(1'b0, 1'b0);
         obs = {q, rise, fall, busy};
         exp_v = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
         n_checks++;
         if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL reset edge %0d: got %b expected %b", k, obs, exp_v);
         end else $display("reset edge %0d: %b", k, obs);
      end
   endtask

   task automatic test_clean_rise();
      logic [3:0] exp_tbl [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                  4'b0001, 4'b1100, 4'b1000, 4'b1000};
      logic [3:0] exp_v;
      logic [3:0] obs;
      for (int k = 0; k < 8; k++) sb.push_back(exp_tbl[k]);
      for (int k = 1; k <= 8; k++) begin
         drive_edge(1'b1, 1'b0);
         obs = {q, rise, fall, busy};
         exp_v = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
         n_checks++;
         if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL clean_rise edge %0d: got %b expected %b", k, obs, exp_v);
         end else $display("clean_rise edge %0d: %b", k, obs);
      end
   endtask

   task automatic test_clean_fall();
      logic [3:0] exp_tbl [8] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001,
                                  4'b1001, 4'b0010, 4'b0000, 4'b0000};
      logic [3:0] exp_v;
      logic [3:0] obs;
      int         fall_cnt = 0;
      for (int k = 0; k < 8; k++) sb.push_back(exp_tbl[k]);
      for (int k = 1; k <= 8; k++) begin
         drive_edge(1'b0, 1'b0);
         obs = {q, rise, fall, busy};
         if (fall) fall_cnt++;
         exp_v = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
         n_checks++;
         if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL clean_fall edge %0d: got %b expected %b", k, obs, exp_v);
         end else $display("clean_fall edge %0d: %b", k, obs);
      end
      n_checks++;
      if (fall_cnt != 1) begin
         n_fails++;
         $display("FAIL clean_fall pulse count: got %0d expected 1", fall_cnt);
      end
   endtask

   task automatic test_glitch();
      logic [3:0] exp_tbl [9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                                  4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic [3:0] exp_v;
      logic [3:0] obs;
      for (int k = 0; k < 9; k++) sb.push_back(exp_tbl[k]);
      for (int k = 1; k <= 9; k++) begin
         drive_edge((k <= 3) ? 1'b1 : 1'b0, 1'b0);
         obs = {q, rise, fall, busy};
         exp_v = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
         n_checks++;
         if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL glitch edge %0d: got %b expected %b", k, obs, exp_v);
         end else $display("glitch edge %0d: %b", k, obs);
      end
   endtask

   task automatic test_reset_mid();
      // Edges 1-3 qualify d=1, edge 4 is reset, then edges 5-11 restart from scratch
      // (first rst=0 sampling edge is 5, so q rises at edge 10), then q returns to 0.
      logic [3:0] exp_tbl [19] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000,
                                   4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                                   4'b1100, 4'b1000,
                                   4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001,
                                   4'b0010, 4'b0000, 4'b0000};
      logic [3:0] exp_v;
      logic [3:0] obs;
      for (int k = 0; k < 19; k++) sb.push_back(exp_tbl[k]);
      for (int k = 1; k <= 19; k++) begin
         drive_edge((k <= 11) ? 1'b1 : 1'b0, (k == 4) ? 1'b1 : 1'b0);
         obs = {q, rise, fall, busy};
         exp_v = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
         n_checks++;
         if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL reset_mid edge %0d: got %b expected %b", k, obs, exp_v);
         end else $display("reset_mid edge %0d: %b", k, obs);
      end
   endtask

   task automatic test_bounce();
      // d = 1,0,1,0... on edges 1-10, held 1 from edge 11; the FSM sees each
      // sample two edges later, so busy flickers on odd edges 3-11 and the
      // final level is accepted at edge 16 (6 edges counting from edge 11).
      logic [3:0] exp_v;
      logic [3:0] obs;
      int         rise_cnt = 0;
      for (int k = 1; k <= 18; k++) begin
         logic eq, er, eb;
         eq = (k >= 16);
         er = (k == 16);
         eb = ((k >= 3) && (k <= 11) && (k % 2 == 1)) || ((k >= 13) && (k <= 15));
         sb.push_back({eq, er, 1'b0, eb});
      end
      for (int k = 1; k <= 18; k++) begin
         drive_edge((k > 10) ? 1'b1 : ((k % 2 == 1) ? 1'b1 : 1'b0), 1'b0);
         obs = {q, rise, fall, busy};
         if (rise) rise_cnt++;
         exp_v = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
         n_checks++;
         if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL bounce edge %0d: got %b expected %b", k, obs, exp_v);
         end else $display("bounce edge %0d: %b", k, obs);
      end
      n_checks++;
      if (rise_cnt != 1) begin
         n_fails++;
         $display("FAIL bounce pulse count: got %0d expected 1", rise_cnt);
      end
   endtask

   task automatic test_back_to_back();
      // From q=1: d=0 on edges 1-4 gives fall at edge 6; d=1 from edge 5 means
      // the FSM sees the opposite level at edge 7 and enters CHK immediately.
      logic [3:0] exp_tbl [11] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001,
                                   4'b0010, 4'b0001, 4'b0001, 4'b0001,
                                   4'b1100, 4'b1000};
      logic [3:0] exp_v;
      logic [3:0] obs;
      for (int k = 0; k < 11; k++) sb.push_back(exp_tbl[k]);
      for (int k = 1; k <= 11; k++) begin
         drive_edge((k <= 4) ? 1'b0 : 1'b1, 1'b0);
         obs = {q, rise, fall, busy};
         exp_v = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
         n_checks++;
         if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL back_to_back edge %0d: got %b expected %b", k, obs, exp_v);
         end else $display("back_to_back edge %0d: %b", k, obs);
      end
   endtask

   initial begin
      test_reset();
      test_clean_rise();
      test_clean_fall();
      test_glitch();
      test_reset_mid();
      test_bounce();
      test_back_to_back();
      n_checks++;
      if (sb.size() != 0) begin
         n_fails++;
         $display("FAIL scoreboard drain: got %0d leftover expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
